// File: rtl/pq_sched_pkg.sv
// Shared types and helpers for the priority-queue access scheduler.
package pq_sched_pkg;

    typedef enum logic [1:0] {
        PQ_ENQ  = 2'd0,
        PQ_DEQ  = 2'd1,
        PQ_REPL = 2'd2,
        PQ_RSVD = 2'd3
    } pq_op_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } sched_state_t;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/pq_access_scheduler_rr_arbiter.sv
// Combinational round-robin picker: first eligible index at or after ptr, wrapping.
module rr_arbiter #(
    parameter  int N  = 4,
    localparam int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  elig,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] winner
);

    // Walk offsets from farthest to nearest so the nearest eligible client wins.
    always_comb begin
        int k;
        grant  = '0;
        winner = '0;
        k      = 0;
        for (int i = N - 1; i >= 0; i--) begin
            k = (int'(ptr) + i) % N;
            if (elig[k]) begin
                grant    = '0;
                grant[k] = 1'b1;
                winner   = IW'(k);
            end
        end
    end

endmodule

// File: rtl/pq_access_scheduler.sv
// Shares one priority queue among NUM_CLIENTS requesters; one command in flight,
// followed by an op-dependent settle gap.
//   state | meaning
//   IDLE  | arbitrate eligible requests, grant is combinational
//   ISSUE | one-cycle queue command and client response
//   WAIT  | settle gap countdown, no commands
module pq_access_scheduler
    import pq_sched_pkg::*;
#(
    parameter int NUM_CLIENTS = 4,
    parameter int DATA_WIDTH  = 16,
    parameter int ENQ_GAP     = 4,
    parameter int DEQ_GAP     = 24,
    parameter int REPL_GAP    = 4
) (
    input  logic                              CLK,
    input  logic                              RSTn,
    input  logic [NUM_CLIENTS-1:0]            i_req_valid,
    input  logic [2*NUM_CLIENTS-1:0]          i_req_op,
    input  logic [DATA_WIDTH*NUM_CLIENTS-1:0] i_req_data,
    output logic [NUM_CLIENTS-1:0]            o_req_ready,
    output logic [NUM_CLIENTS-1:0]            o_resp_valid,
    output logic [DATA_WIDTH-1:0]             o_resp_data,
    output logic                              o_pq_wrt,
    output logic                              o_pq_read,
    output logic [DATA_WIDTH-1:0]             o_pq_data,
    input  logic                              i_pq_full,
    input  logic                              i_pq_empty,
    input  logic [DATA_WIDTH-1:0]             i_pq_top,
    output logic                              o_busy
);

    localparam int IW      = (NUM_CLIENTS > 1) ? $clog2(NUM_CLIENTS) : 1;
    localparam int MAX_GAP = max3(ENQ_GAP, DEQ_GAP, REPL_GAP);
    localparam int CW      = (MAX_GAP > 0) ? $clog2(MAX_GAP + 1) : 1;

    sched_state_t            state, state_d;
    pq_op_t                  lat_op, op_d, win_op;
    logic [IW-1:0]           rr_ptr, rr_d, winner;
    logic [CW-1:0]           gap_cnt, gap_d, issue_gap;
    logic [NUM_CLIENTS-1:0]  elig, grant, resp_valid_d;
    logic [DATA_WIDTH-1:0]   win_data, pq_data_d, resp_data_d;
    logic                    wrt_d, read_d, handshake;

    // REPL keeps the queue size constant, so only emptiness gates it.
    always_comb begin
        elig = '0;
        for (int k = 0; k < NUM_CLIENTS; k++) begin
            case (pq_op_t'(i_req_op[2*k +: 2]))
                PQ_ENQ:          elig[k] = i_req_valid[k] & ~i_pq_full;
                PQ_DEQ, PQ_REPL: elig[k] = i_req_valid[k] & ~i_pq_empty;
                default:         elig[k] = 1'b0;
            endcase
        end
    end

    rr_arbiter #(.N(NUM_CLIENTS)) u_arb (
        .elig   (elig),
        .ptr    (rr_ptr),
        .grant  (grant),
        .winner (winner)
    );

    assign o_req_ready = (state == IDLE && RSTn) ? grant : '0;
    assign handshake   = |o_req_ready;
    assign o_busy      = (state != IDLE);
    assign win_op      = pq_op_t'(i_req_op[2*winner +: 2]);
    assign win_data    = i_req_data[DATA_WIDTH*winner +: DATA_WIDTH];

    always_comb begin
        case (lat_op)
            PQ_ENQ:  issue_gap = CW'(ENQ_GAP);
            PQ_DEQ:  issue_gap = CW'(DEQ_GAP);
            default: issue_gap = CW'(REPL_GAP);
        endcase
    end

    always_comb begin
        state_d      = state;
        op_d         = lat_op;
        rr_d         = rr_ptr;
        gap_d        = gap_cnt;
        wrt_d        = 1'b0;
        read_d       = 1'b0;
        pq_data_d    = '0;
        resp_valid_d = '0;
        resp_data_d  = '0;
        case (state)
            IDLE: begin
                if (handshake) begin
                    op_d         = win_op;
                    rr_d         = (winner == IW'(NUM_CLIENTS - 1)) ? '0 : winner + 1'b1;
                    wrt_d        = (win_op != PQ_DEQ);
                    read_d       = (win_op != PQ_ENQ);
                    pq_data_d    = win_data;
                    resp_valid_d = o_req_ready;
                    resp_data_d  = (win_op == PQ_ENQ) ? '0 : i_pq_top;
                    state_d      = ISSUE;
                end
            end
            ISSUE: begin
                gap_d   = issue_gap;
                state_d = (issue_gap == '0) ? IDLE : WAIT;
            end
            WAIT: begin
                if (gap_cnt > CW'(1)) begin
                    gap_d = gap_cnt - 1'b1;
                end else begin
                    gap_d   = '0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            state        <= IDLE;
            lat_op       <= PQ_ENQ;
            rr_ptr       <= '0;
            gap_cnt      <= '0;
            o_pq_wrt     <= 1'b0;
            o_pq_read    <= 1'b0;
            o_pq_data    <= '0;
            o_resp_valid <= '0;
            o_resp_data  <= '0;
        end else begin
            state        <= state_d;
            lat_op       <= op_d;
            rr_ptr       <= rr_d;
            gap_cnt      <= gap_d;
            o_pq_wrt     <= wrt_d;
            o_pq_read    <= read_d;
            o_pq_data    <= pq_data_d;
            o_resp_valid <= resp_valid_d;
            o_resp_data  <= resp_data_d;
        end
    end

endmodule

// File: tb/tb_pq_access_scheduler.sv
// Directed bench for pq_access_scheduler: grant timing, gaps, eligibility, round-robin, reset.
module tb_pq_access_scheduler;

    localparam logic [1:0] ENQ  = 2'd0;
    localparam logic [1:0] DEQ  = 2'd1;
    localparam logic [1:0] REPL = 2'd2;

    logic        CLK = 1'b0;
    logic        RSTn;
    logic [3:0]  valid;
    logic [7:0]  op;
    logic [63:0] data;
    logic [3:0]  ready, resp_valid;
    logic [15:0] resp_data, pq_data, top;
    logic        wrt, read, full, empty, busy;

    int tests = 0;
    int fails = 0;

    always #5 CLK = ~CLK;

    pq_access_scheduler dut (
        .CLK          (CLK),
        .RSTn         (RSTn),
        .i_req_valid  (valid),
        .i_req_op     (op),
        .i_req_data   (data),
        .o_req_ready  (ready),
        .o_resp_valid (resp_valid),
        .o_resp_data  (resp_data),
        .o_pq_wrt     (wrt),
        .o_pq_read    (read),
        .o_pq_data    (pq_data),
        .i_pq_full    (full),
        .i_pq_empty   (empty),
        .i_pq_top     (top),
        .o_busy       (busy)
    );

    task automatic tick;
        @(posedge CLK);
        #1;
    endtask

    task automatic set_req(input int k, input logic v, input logic [1:0] o, input logic [15:0] d);
        valid[k]       = v;
        op[2*k +: 2]   = o;
        data[16*k +: 16] = d;
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        while (busy !== 1'b0 && n < 60) begin
            tick();
            n++;
        end
        tests++;
        if (busy !== 1'b0) begin
            fails++;
            $display("FAIL %s idle timeout: busy=%b required 0", name, busy);
        end
    endtask

    task automatic test_reset;
        RSTn = 1'b0; valid = '0; op = '0; data = '0;
        full = 1'b0; empty = 1'b1; top = '0;
        #3;
        tests++; if (ready !== 4'b0) begin fails++; $display("FAIL rst_ready: got %b required 0000", ready); end
        tests++; if (resp_valid !== 4'b0) begin fails++; $display("FAIL rst_resp_valid: got %b required 0000", resp_valid); end
        tests++; if ({wrt, read, busy} !== 3'b0) begin fails++; $display("FAIL rst_cmd: wrt/read/busy=%b required 000", {wrt, read, busy}); end
        tests++; if (pq_data !== 16'h0 || resp_data !== 16'h0) begin fails++; $display("FAIL rst_data: pq_data=%h resp_data=%h required 0", pq_data, resp_data); end
        tick(); tick();
        RSTn = 1'b1;
        tick();
    endtask

    task automatic test_enq;
        empty = 1'b1; full = 1'b0;
        set_req(1, 1'b1, ENQ, 16'h0123);
        #1;
        tests++; if (ready !== 4'b0010) begin fails++; $display("FAIL enq_ready: got %b required 0010", ready); end
        tick();
        set_req(1, 1'b0, ENQ, 16'h0);
        set_req(0, 1'b1, ENQ, 16'h0AAA);
        #1;
        tests++; if (wrt !== 1'b1 || read !== 1'b0) begin fails++; $display("FAIL enq_cmd: wrt=%b read=%b required 1 0", wrt, read); end
        tests++; if (pq_data !== 16'h0123) begin fails++; $display("FAIL enq_pq_data: got %h required 0123", pq_data); end
        tests++; if (resp_valid !== 4'b0010 || resp_data !== 16'h0) begin fails++; $display("FAIL enq_resp: valid=%b data=%h required 0010 0000", resp_valid, resp_data); end
        tests++; if (busy !== 1'b1) begin fails++; $display("FAIL enq_busy_issue: got %b required 1", busy); end
        for (int n = 2; n <= 5; n++) begin
            tick();
            tests++;
            if (busy !== 1'b1 || ready !== 4'b0 || wrt !== 1'b0 || resp_valid !== 4'b0) begin
                fails++;
                $display("FAIL enq_gap T+%0d: busy=%b ready=%b wrt=%b resp_valid=%b required 1 0000 0 0000", n, busy, ready, wrt, resp_valid);
            end
        end
        tick();
        tests++; if (ready !== 4'b0001 || busy !== 1'b0) begin fails++; $display("FAIL enq_next_grant T+6: ready=%b busy=%b required 0001 0", ready, busy); end
        tick();
        set_req(0, 1'b0, ENQ, 16'h0);
        wait_idle("enq");
    endtask

    task automatic test_deq;
        int gap_n = -1;
        empty = 1'b0; full = 1'b0; top = 16'h0400;
        set_req(2, 1'b1, DEQ, 16'h0);
        #1;
        tests++; if (ready !== 4'b0100) begin fails++; $display("FAIL deq_ready: got %b required 0100", ready); end
        tick();
        set_req(2, 1'b0, DEQ, 16'h0);
        set_req(3, 1'b1, REPL, 16'h0033);
        #1;
        tests++; if (read !== 1'b1 || wrt !== 1'b0) begin fails++; $display("FAIL deq_cmd: wrt=%b read=%b required 0 1", wrt, read); end
        tests++; if (resp_valid !== 4'b0100 || resp_data !== 16'h0400) begin fails++; $display("FAIL deq_resp: valid=%b data=%h required 0100 0400", resp_valid, resp_data); end
        for (int n = 1; n <= 40; n++) begin
            tick();
            if (ready !== 4'b0) begin
                gap_n = n;
                break;
            end
        end
        tests++; if (gap_n != 25) begin fails++; $display("FAIL deq_gap: first grant %0d cycles after issue, required 25", gap_n); end
        tests++; if (ready !== 4'b1000) begin fails++; $display("FAIL deq_next_winner: got %b required 1000", ready); end
        tick();
        set_req(3, 1'b0, ENQ, 16'h0);
        wait_idle("deq");
    endtask

    task automatic test_repl_rr;
        logic [3:0] gv[5];
        int gcyc[5];
        int ng = 0;
        int cyc = 0;
        empty = 1'b0; full = 1'b0; top = 16'h0777;
        for (int k = 0; k < 4; k++) set_req(k, 1'b1, REPL, 16'(k + 1));
        #1;
        while (ng < 5 && cyc < 60) begin
            if (ready !== 4'b0) begin
                gv[ng] = ready;
                gcyc[ng] = cyc;
                tick();
                cyc++;
                tests++;
                if (wrt !== 1'b1 || read !== 1'b1) begin fails++; $display("FAIL repl_pair %0d: wrt=%b read=%b required 1 1", ng, wrt, read); end
                ng++;
            end else begin
                tick();
                cyc++;
            end
        end
        for (int k = 0; k < 4; k++) set_req(k, 1'b0, ENQ, 16'h0);
        tests++; if (ng != 5) begin fails++; $display("FAIL repl_count: got %0d grants required 5", ng); end
        for (int i = 0; i < ng; i++) begin
            tests++;
            if (gv[i] !== 4'(1 << (i % 4))) begin fails++; $display("FAIL repl_order %0d: got %b required %b", i, gv[i], 4'(1 << (i % 4))); end
            if (i > 0) begin
                tests++;
                if (gcyc[i] - gcyc[i-1] != 6) begin fails++; $display("FAIL repl_spacing %0d: got %0d required 6", i, gcyc[i] - gcyc[i-1]); end
            end
        end
        wait_idle("repl");
    endtask

    task automatic test_empty;
        empty = 1'b1; full = 1'b0; top = 16'h0055;
        set_req(0, 1'b1, DEQ, 16'h0);
        set_req(3, 1'b1, ENQ, 16'h0010);
        #1;
        tests++; if (ready !== 4'b1000) begin fails++; $display("FAIL empty_ready: got %b required 1000", ready); end
        tick();
        set_req(3, 1'b0, ENQ, 16'h0);
        #1;
        tests++; if (wrt !== 1'b1 || pq_data !== 16'h0010 || resp_valid !== 4'b1000) begin fails++; $display("FAIL empty_enq: wrt=%b data=%h resp_valid=%b required 1 0010 1000", wrt, pq_data, resp_valid); end
        wait_idle("empty_enq");
        tick();
        tests++; if (ready !== 4'b0 || busy !== 1'b0) begin fails++; $display("FAIL empty_pending: ready=%b busy=%b required 0000 0", ready, busy); end
        empty = 1'b0;
        #1;
        tests++; if (ready !== 4'b0001) begin fails++; $display("FAIL empty_release: got %b required 0001", ready); end
        tick();
        set_req(0, 1'b0, ENQ, 16'h0);
        #1;
        tests++; if (read !== 1'b1 || resp_valid !== 4'b0001 || resp_data !== 16'h0055) begin fails++; $display("FAIL empty_deq: read=%b resp_valid=%b data=%h required 1 0001 0055", read, resp_valid, resp_data); end
        wait_idle("empty_deq");
    endtask

    task automatic test_full;
        full = 1'b1; empty = 1'b0; top = 16'h0999;
        set_req(1, 1'b1, ENQ, 16'h0042);
        set_req(2, 1'b1, REPL, 16'h0005);
        #1;
        tests++; if (ready !== 4'b0100) begin fails++; $display("FAIL full_ready: got %b required 0100", ready); end
        tick();
        set_req(2, 1'b0, ENQ, 16'h0);
        #1;
        tests++; if (wrt !== 1'b1 || read !== 1'b1 || pq_data !== 16'h0005) begin fails++; $display("FAIL full_repl: wrt=%b read=%b data=%h required 1 1 0005", wrt, read, pq_data); end
        tests++; if (resp_valid !== 4'b0100 || resp_data !== 16'h0999) begin fails++; $display("FAIL full_resp: valid=%b data=%h required 0100 0999", resp_valid, resp_data); end
        wait_idle("full");
        tick();
        tests++; if (ready !== 4'b0) begin fails++; $display("FAIL full_enq_blocked: got %b required 0000", ready); end
        set_req(1, 1'b0, ENQ, 16'h0);
        full = 1'b0;
    endtask

    task automatic test_reset_mid;
        empty = 1'b0; full = 1'b0; top = 16'h0321;
        set_req(2, 1'b1, DEQ, 16'h0);
        #1;
        tests++; if (ready !== 4'b0100) begin fails++; $display("FAIL rmid_ready: got %b required 0100", ready); end
        tick();
        set_req(2, 1'b0, ENQ, 16'h0);
        tick(); tick(); tick();
        for (int k = 0; k < 4; k++) set_req(k, 1'b1, ENQ, 16'(16'h0100 + k));
        RSTn = 1'b0;
        #1;
        tests++; if (busy !== 1'b0 || ready !== 4'b0) begin fails++; $display("FAIL rmid_async: busy=%b ready=%b required 0 0000", busy, ready); end
        tests++; if ({wrt, read} !== 2'b0 || resp_valid !== 4'b0 || resp_data !== 16'h0 || pq_data !== 16'h0) begin fails++; $display("FAIL rmid_outputs: wrt/read=%b resp_valid=%b resp_data=%h pq_data=%h required 0", {wrt, read}, resp_valid, resp_data, pq_data); end
        tick(); tick();
        tests++; if (resp_valid !== 4'b0 || ready !== 4'b0) begin fails++; $display("FAIL rmid_hold: resp_valid=%b ready=%b required 0000 0000", resp_valid, ready); end
        RSTn = 1'b1;
        #1;
        tests++; if (ready !== 4'b0001) begin fails++; $display("FAIL rmid_first_grant: got %b required 0001", ready); end
        tick();
        for (int k = 0; k < 4; k++) set_req(k, 1'b0, ENQ, 16'h0);
        #1;
        tests++; if (resp_valid !== 4'b0001 || wrt !== 1'b1 || read !== 1'b0 || pq_data !== 16'h0100) begin fails++; $display("FAIL rmid_issue: resp_valid=%b wrt=%b read=%b data=%h required 0001 1 0 0100", resp_valid, wrt, read, pq_data); end
        wait_idle("rmid");
    endtask

    initial begin
        test_reset();
        test_enq();
        test_deq();
        test_repl_rr();
        test_empty();
        test_full();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
